// File: rtl/dmem_responder.sv
// Dmem bus target: serves one LOAD/STORE at a time, completing LATENCY cycles after acceptance.
// Build option: define DMEM_MISALIGN_ERR_EN to fail accesses whose addr[1:0] != 0.
module dmem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [31:0] proc2Dmem_addr,
  input  logic [31:0] proc2Dmem_data,
  output logic [31:0] Dmem2proc_data,
  output logic        Dmem2proc_valid,
  output logic        Dmem2proc_err,
  output logic        Dmem2proc_busy
);

  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;
  localparam int         IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "dmem_responder: LATENCY=%0d outside legal range 1..15", LATENCY);
  end

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               store_q;
  logic               err_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;
  logic [31:0]        mem_q [MEM_WORDS];

  logic accept;
  logic req_err;

  assign accept = (state_q == IDLE) &&
                  ((proc2Dmem_command == BUS_LOAD) || (proc2Dmem_command == BUS_STORE));

  // Out-of-range (and optionally misaligned) requests still complete, just flagged.
`ifdef DMEM_MISALIGN_ERR_EN
  assign req_err = ({2'b00, proc2Dmem_addr[31:2]} >= 32'(MEM_WORDS)) ||
                   (proc2Dmem_addr[1:0] != 2'b00);
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^proc2Dmem_addr[1:0];
  assign req_err = ({2'b00, proc2Dmem_addr[31:2]} >= 32'(MEM_WORDS));
`endif

  // NOTE: every output of always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      store_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      store_q <= (proc2Dmem_command == BUS_STORE);
      err_q   <= req_err;
      idx_q   <= proc2Dmem_addr[IDX_W+1:2];
      wdata_q <= proc2Dmem_data;
    end
  end

  // NOTE: the storage array has no reset; rst only blocks a store completing on the same edge.
  always_ff @(posedge clk) begin
    if (rst && (state_q == DONE) && store_q && !err_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign Dmem2proc_valid = (state_q == DONE);
  assign Dmem2proc_busy  = (state_q == WAIT);
  assign Dmem2proc_err   = Dmem2proc_valid && err_q;
  assign Dmem2proc_data  = (Dmem2proc_valid && !store_q && !err_q) ? mem_q[idx_q] : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: LATENCY=2 main instance plus a LATENCY=1 instance,
// compared against an address-indexed model of the storage and the completion timing rules.
module tb_dmem_responder;

  localparam int         LAT       = 2;
  localparam int         MEM_WORDS = 1024;
  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cmd;
  logic [31:0] addr_r, wdata_r;
  logic [31:0] rdata;
  logic        valid, err, busy;

  logic [1:0]  c1_cmd;
  logic [31:0] c1_addr, c1_wdata;
  logic [31:0] d1_rdata;
  logic        d1_valid, d1_err, d1_busy;

  int errors = 0;
  int checks = 0;
  int busy1_seen = 0;

  logic [31:0] model_mem [int];

  always #5 clk = ~clk;

  dmem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .proc2Dmem_command(cmd), .proc2Dmem_addr(addr_r), .proc2Dmem_data(wdata_r),
    .Dmem2proc_data(rdata), .Dmem2proc_valid(valid),
    .Dmem2proc_err(err), .Dmem2proc_busy(busy)
  );

  dmem_responder #(.MEM_WORDS(64), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .proc2Dmem_command(c1_cmd), .proc2Dmem_addr(c1_addr), .proc2Dmem_data(c1_wdata),
    .Dmem2proc_data(d1_rdata), .Dmem2proc_valid(d1_valid),
    .Dmem2proc_err(d1_err), .Dmem2proc_busy(d1_busy)
  );

  always @(negedge clk) if (d1_busy === 1'b1) busy1_seen++;

  // One request on the LATENCY=2 instance, starting in an IDLE cycle and ending in the next one.
  task automatic txn(input bit is_store, input logic [31:0] a, input logic [31:0] d, input string name);
    int idx;
    bit exp_err, known;
    logic [31:0] exp_data;
    idx     = int'(a[31:2]);
    exp_err = (idx >= MEM_WORDS);
`ifdef DMEM_MISALIGN_ERR_EN
    if (a[1:0] != 2'b00) exp_err = 1'b1;
`endif
    known    = is_store || exp_err || model_mem.exists(idx);
    exp_data = (is_store || exp_err || !known) ? 32'h0 : model_mem[idx];
    cmd = is_store ? BUS_STORE : BUS_LOAD;
    addr_r = a;
    wdata_r = d;
    @(posedge clk); #1;
    cmd = BUS_NONE;
    for (int k = 1; k <= LAT; k++) begin
      checks++;
      if ({busy, valid} !== {k < LAT, k == LAT}) begin
        errors++;
        $display("FAIL %s cycle+%0d busy/valid: got %b%b want %b%b", name, k, busy, valid, k < LAT, k == LAT);
      end
      if (k == LAT) begin
        checks++;
        if (err !== exp_err) begin
          errors++;
          $display("FAIL %s err: got %b want %b", name, err, exp_err);
        end
        if (known) begin
          checks++;
          if (rdata !== exp_data) begin
            errors++;
            $display("FAIL %s data: got %h want %h", name, rdata, exp_data);
          end
        end
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({valid, busy, err, rdata} !== 35'h0) begin
      errors++;
      $display("FAIL %s idle-after: got v=%b b=%b e=%b d=%h want all 0", name, valid, busy, err, rdata);
    end
    if (is_store && !exp_err) model_mem[idx] = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cmd = BUS_STORE; addr_r = 32'h100; wdata_r = 32'h0000_0001;
    c1_cmd = BUS_NONE; c1_addr = 32'h0; c1_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({valid, busy, err, rdata} !== 35'h0) begin
        errors++;
        $display("FAIL reset_initial cycle %0d: got v=%b b=%b e=%b d=%h want all 0", i, valid, busy, err, rdata);
      end
    end
    rst = 1'b1; cmd = BUS_NONE;
    @(posedge clk); #1;
    txn(1'b1, 32'h100, 32'h1111_2222, "reset_prestore");
    rst = 1'b0;
    cmd = BUS_STORE; addr_r = 32'h100; wdata_r = 32'h9999_9999;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({valid, busy, err, rdata} !== 35'h0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got v=%b b=%b e=%b d=%h want all 0", i, valid, busy, err, rdata);
      end
    end
    rst = 1'b1; cmd = BUS_NONE;
    @(posedge clk); #1;
    txn(1'b0, 32'h100, 32'h0, "reset_no_write");
  endtask

  task automatic test_store_load();
    txn(1'b1, 32'h40, 32'hDEAD_BEEF, "store_40");
    txn(1'b0, 32'h40, 32'h0, "load_40");
  endtask

  task automatic test_hold();
    txn(1'b1, 32'h200, 32'hAAAA_0001, "hold_pre_a");
    txn(1'b1, 32'h204, 32'hBBBB_0002, "hold_pre_b");
    cmd = BUS_LOAD; addr_r = 32'h200;
    @(posedge clk); #1;
    addr_r = 32'h204;
    checks++;
    if ({busy, valid} !== 2'b10) begin
      errors++; $display("FAIL hold N+1 busy/valid: got %b%b want 10", busy, valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, valid, rdata} !== {2'b01, 32'hAAAA_0001}) begin
      errors++; $display("FAIL hold N+2 first: got b=%b v=%b d=%h want b=0 v=1 d=aaaa0001", busy, valid, rdata);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, valid} !== 2'b00) begin
      errors++; $display("FAIL hold N+3 idle: got %b%b want 00", busy, valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, valid} !== 2'b10) begin
      errors++; $display("FAIL hold N+4 busy/valid: got %b%b want 10", busy, valid);
    end
    @(posedge clk); #1;
    cmd = BUS_NONE;
    checks++;
    if ({busy, valid, err, rdata} !== {3'b010, 32'hBBBB_0002}) begin
      errors++; $display("FAIL hold N+5 second: got b=%b v=%b e=%b d=%h want v=1 d=bbbb0002", busy, valid, err, rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    txn(1'b1, 32'h0000_0000, 32'h0F0F_0F0F, "oor_pre_w0");
    txn(1'b1, 32'h0000_0FFC, 32'hF0F0_F0F0, "oor_pre_w1023");
    txn(1'b0, 32'h0000_1000, 32'h0, "oor_load");
    txn(1'b1, 32'h0000_1000, 32'h7777_7777, "oor_store");
    txn(1'b1, 32'hFFFF_FFFC, 32'h6666_6666, "oor_store_top");
    txn(1'b0, 32'h0000_0000, 32'h0, "oor_w0_intact");
    txn(1'b0, 32'h0000_0FFC, 32'h0, "oor_w1023_intact");
  endtask

  task automatic test_reset_midflight();
    txn(1'b1, 32'h80, 32'hCAFE_F00D, "mid_pre");
    cmd = BUS_STORE; addr_r = 32'h80; wdata_r = 32'h1234_5678;
    @(posedge clk); #1;
    cmd = BUS_NONE; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({valid, busy} !== 2'b00) begin
        errors++; $display("FAIL mid_wait_reset cycle %0d: got v=%b b=%b want 00", i, valid, busy);
      end
      @(posedge clk); #1;
    end
    txn(1'b0, 32'h80, 32'h0, "mid_wait_no_commit");
    cmd = BUS_STORE; addr_r = 32'h80; wdata_r = 32'h5555_5555;
    @(posedge clk); #1;
    cmd = BUS_NONE;
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b1) begin
      errors++; $display("FAIL mid_done valid: got %b want 1", valid);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL mid_done_reset valid: got %b want 0", valid);
    end
    @(posedge clk); #1;
    txn(1'b0, 32'h80, 32'h0, "mid_done_no_commit");
  endtask

  task automatic test_misalign();
    txn(1'b1, 32'h42, 32'hA5A5_A5A5, "misalign_store");
    txn(1'b0, 32'h40, 32'h0, "misalign_load_aligned");
    txn(1'b0, 32'h43, 32'h0, "misalign_load_odd");
  endtask

  task automatic test_latency1();
    c1_cmd = BUS_STORE; c1_addr = 32'h10; c1_wdata = 32'h0BAD_CAFE;
    @(posedge clk); #1;
    checks++;
    if ({d1_valid, d1_busy, d1_err, d1_rdata} !== {3'b100, 32'h0}) begin
      errors++; $display("FAIL lat1_store N+1: got v=%b b=%b e=%b d=%h want v=1", d1_valid, d1_busy, d1_err, d1_rdata);
    end
    c1_cmd = BUS_LOAD;
    @(posedge clk); #1;
    checks++;
    if (d1_valid !== 1'b0) begin
      errors++; $display("FAIL lat1_idle valid: got %b want 0", d1_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({d1_valid, d1_err, d1_rdata} !== {2'b10, 32'h0BAD_CAFE}) begin
      errors++; $display("FAIL lat1_load: got v=%b e=%b d=%h want v=1 e=0 d=0badcafe", d1_valid, d1_err, d1_rdata);
    end
    c1_addr = 32'h100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    c1_cmd = BUS_NONE;
    checks++;
    if ({d1_valid, d1_err, d1_rdata} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL lat1_oor: got v=%b e=%b d=%h want v=1 e=1 d=0", d1_valid, d1_err, d1_rdata);
    end
    @(posedge clk); #1;
    checks++;
    if (busy1_seen !== 0) begin
      errors++; $display("FAIL lat1_busy_never: got %0d busy cycles want 0", busy1_seen);
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [16];
    logic [31:0] a;
    int kind;
    pool[0] = 32'h0; pool[1] = 32'hFFC;
    for (int i = 2; i < 16; i++) pool[i] = {20'h0, 10'($urandom_range(0, MEM_WORDS - 1)), 2'b00};
    for (int i = 0; i < 16; i++) txn(1'b1, pool[i], $urandom, "rand_init");
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 7);
      a = pool[$urandom_range(0, 15)] | 32'($urandom_range(0, 3) * int'(kind == 7));
      if (kind == 6) a = $urandom | 32'h0000_1000;
      txn(kind[0], a, $urandom, "rand_op");
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_hold();
    test_out_of_range();
    test_reset_midflight();
    test_misalign();
    test_latency1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
